// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the 16-bit MIPS fetch/hazard control slice:
//   - state_e    : fetch sequencer state encoding (RUN/STALL/FLUSH/HALT)
//   - REG_W      : register index width (8 architectural registers)
//   - WORD_W     : datapath / performance counter width
//   - sat_inc()  : saturating increment used by the performance counters
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int REG_W  = 3;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] value);
        logic [WORD_W-1:0] result;
        if (value == {WORD_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(WORD_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard comparator. Flags when the load currently in
// EX writes a register that the instruction in IF/ID reads.
// Ports:
//   ex_mem_read  in   EX instruction is a load
//   ex_rd        in   EX destination register
//   id_rs        in   IF/ID source register 1 (always read)
//   id_rt        in   IF/ID source register 2
//   id_uses_rt   in   IF/ID instruction actually reads id_rt
//   load_use     out  hazard detected
// Parameter R0_HARDWIRED=1 masks register 0, which is constant and can never
// carry a dependency.
// -----------------------------------------------------------------------------
module load_use_detect
    import mips_ctrl_pkg::*;
#(
    parameter int R0_HARDWIRED = 1
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             load_use
);

    logic rs_match_s;
    logic rt_match_s;
    logic rd_valid_s;

    // Register-match terms and the optional register-0 qualifier.
    always_comb begin
        rs_match_s = (ex_rd == id_rs);
        rt_match_s = id_uses_rt & (ex_rd == id_rt);
        if (R0_HARDWIRED != 0) begin
            rd_valid_s = (ex_rd != {REG_W{1'b0}});
        end else begin
            rd_valid_s = 1'b1;
        end
        load_use = ex_mem_read & rd_valid_s & (rs_match_s | rt_match_s);
    end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_hazard_ctrl
// Sequences the 16-bit MIPS fetch stage: resolves load-use stalls, taken-branch
// flushes and halt/resume, and drives the fetch stage plus IF/ID and ID/EX
// pipeline-register controls. All control outputs are combinational from the
// registered state and the current inputs, so a decision acts in the cycle it
// is made.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   id_rs, id_rt        IF/ID source registers, id_uses_rt qualifies id_rt
//   ex_mem_read, ex_rd  EX-stage load flag and destination register
//   ex_branch_tkn       EX branch resolved taken this cycle
//   halt_req, resume    halt request (level) and resume pulse
//   if_enable           fetch PC update enable
//   branch_enable       fetch selects PC+offset
//   ifid_hold/flush     IF/ID keeps value / loads NOP
//   idex_bubble         ID/EX loads NOP
//   stall_cnt/flush_cnt performance counters
// Build option: define HAZ_PERF_CNT_EN to implement the saturating performance
// counters; otherwise both counter outputs are tied to zero.
// cnt holds the number of frozen cycles still to spend in STALL/FLUSH,
// counting the current one; the RUN cycle that triggers the hazard is the
// first of the LOAD_STALL_CYCLES / FLUSH_CYCLES cycles.
// -----------------------------------------------------------------------------
module fetch_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2,
    parameter int R0_HARDWIRED      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_branch_tkn,
    input  logic              halt_req,
    input  logic              resume,
    output logic              if_enable,
    output logic              branch_enable,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [WORD_W-1:0] stall_cnt,
    output logic [WORD_W-1:0] flush_cnt
);

    localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       load_use_s;

    load_use_detect #(
        .R0_HARDWIRED (R0_HARDWIRED)
    ) u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use_s)
    );

    // State and countdown register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; branch outranks load-use, which outranks halt.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_tkn) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end
                end else if (load_use_s) begin
                    // A single-cycle stall needs no STALL state: EX holds the
                    // bubble next cycle, so the hazard has cleared.
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end
                end else if (halt_req) begin
                    state_d = ST_HALT;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end
            end
            ST_STALL, ST_FLUSH: begin
                // EX holds a bubble here, so a reported branch is spurious.
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = state_q;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            ST_HALT: begin
                if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
                cnt_d = 3'd0;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Pipeline control outputs; reset forces NOPs into both pipeline registers.
    always_comb begin
        if_enable     = 1'b0;
        branch_enable = 1'b0;
        ifid_hold     = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_tkn) begin
                        if_enable     = 1'b1;
                        branch_enable = 1'b1;
                        ifid_flush    = 1'b1;
                        idex_bubble   = 1'b1;
                    end else if (load_use_s) begin
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (halt_req) begin
                        ifid_hold = 1'b1;
                    end else begin
                        if_enable = 1'b1;
                    end
                end
                ST_STALL: begin
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end
                ST_FLUSH: begin
                    if_enable   = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                ST_HALT: begin
                    ifid_hold = 1'b1;
                end
                default: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [WORD_W-1:0] stall_cnt_q;
    logic [WORD_W-1:0] stall_cnt_d;
    logic [WORD_W-1:0] flush_cnt_q;
    logic [WORD_W-1:0] flush_cnt_d;
    logic              stall_inc_s;
    logic              flush_inc_s;

    // Counter update: the RUN cycle that detects a load-use counts as a stall.
    always_comb begin
        stall_inc_s = !rst && ((state_q == ST_STALL) ||
                      ((state_q == ST_RUN) && !ex_branch_tkn && load_use_s));
        flush_inc_s = !rst && ifid_flush;
        if (stall_inc_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_inc_s) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {WORD_W{1'b0}};
            flush_cnt_q <= {WORD_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = {WORD_W{1'b0}};
    assign flush_cnt = {WORD_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_hazard_ctrl
// Self-checking bench for fetch_hazard_ctrl with default parameters. Each
// applied vector pushes its expected control word
// {if_enable, branch_enable, ifid_hold, ifid_flush, idex_bubble} into a
// scoreboard queue; the word is popped and compared half a cycle later.
// -----------------------------------------------------------------------------
module tb_fetch_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       mr;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urt;
        logic       halt;
        logic       res;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [2:0]  ex_rd;
    logic        ex_branch_tkn;
    logic        halt_req;
    logic        resume;
    logic        if_enable;
    logic        branch_enable;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int          vectors;
    int          miscompares;
    logic [4:0]  exp_q[$];

    // Expected control words.
    localparam logic [4:0] O_RST    = 5'b00011;
    localparam logic [4:0] O_RUN    = 5'b10000;
    localparam logic [4:0] O_STALL  = 5'b00101;
    localparam logic [4:0] O_BRANCH = 5'b11011;
    localparam logic [4:0] O_FLUSH  = 5'b10011;
    localparam logic [4:0] O_HALT   = 5'b00100;

    fetch_hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .ex_branch_tkn (ex_branch_tkn),
        .halt_req      (halt_req),
        .resume        (resume),
        .if_enable     (if_enable),
        .branch_enable (branch_enable),
        .ifid_hold     (ifid_hold),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic b, input logic m,
                                input logic [2:0] d, input logic [2:0] s,
                                input logic [2:0] t, input logic u,
                                input logic h, input logic p);
        vec_t v;
        v.rst = r; v.br = b; v.mr = m; v.rd = d; v.rs = s; v.rt = t;
        v.urt = u; v.halt = h; v.res = p;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    endfunction

    // Drive one vector after the clock edge, queue its expectation, and move
    // to the falling edge where outputs are stable.
    task automatic cyc(input vec_t v, input logic [4:0] e);
        @(posedge clk);
        #1;
        rst           = v.rst;
        ex_branch_tkn = v.br;
        ex_mem_read   = v.mr;
        ex_rd         = v.rd;
        id_rs         = v.rs;
        id_rt         = v.rt;
        id_uses_rt    = v.urt;
        halt_req      = v.halt;
        resume        = v.res;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t       v[$];
        logic [4:0] e[$];
        logic [4:0] obs;
        logic [4:0] want;
        v.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0)); e.push_back(O_RST);
        v.push_back(mk(1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0)); e.push_back(O_RST);
        v.push_back(idle()); e.push_back(O_RUN);
        v.push_back(idle()); e.push_back(O_RUN);
        for (int i = 0; i < v.size(); i++) begin
            cyc(v[i], e[i]);
            obs  = {if_enable, branch_enable, ifid_hold, ifid_flush, idex_bubble};
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t       v[$];
        logic [4:0] e[$];
        logic [4:0] obs;
        logic [4:0] want;
        // rs hit, then EX holds the bubble
        v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 3'd5, 1'b0, 1'b0, 1'b0)); e.push_back(O_STALL);
        v.push_back(idle()); e.push_back(O_RUN);
        // register 0 never stalls
        v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0)); e.push_back(O_RUN);
        // rt hit only counts when rt is read
        v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd5, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0)); e.push_back(O_STALL);
        v.push_back(idle()); e.push_back(O_RUN);
        v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd5, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0)); e.push_back(O_RUN);
        // register match without a load
        v.push_back(mk(1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0)); e.push_back(O_RUN);
        // back-to-back dependent loads stall each cycle
        v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0)); e.push_back(O_STALL);
        v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd2, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0)); e.push_back(O_STALL);
        v.push_back(idle()); e.push_back(O_RUN);
        for (int i = 0; i < v.size(); i++) begin
            cyc(v[i], e[i]);
            obs  = {if_enable, branch_enable, ifid_hold, ifid_flush, idex_bubble};
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_branch();
        vec_t       v[$];
        logic [4:0] e[$];
        logic [4:0] obs;
        logic [4:0] want;
        v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0)); e.push_back(O_BRANCH);
        // second taken branch during FLUSH is ignored
        v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0)); e.push_back(O_FLUSH);
        v.push_back(idle()); e.push_back(O_RUN);
        // branch beats a simultaneous load-use; the hazard is ignored in FLUSH
        v.push_back(mk(1'b0, 1'b1, 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0)); e.push_back(O_BRANCH);
        v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0)); e.push_back(O_FLUSH);
        v.push_back(idle()); e.push_back(O_RUN);
        // branch beats halt
        v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0)); e.push_back(O_BRANCH);
        v.push_back(idle()); e.push_back(O_FLUSH);
        v.push_back(idle()); e.push_back(O_RUN);
        for (int i = 0; i < v.size(); i++) begin
            cyc(v[i], e[i]);
            obs  = {if_enable, branch_enable, ifid_hold, ifid_flush, idex_bubble};
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL branch[%0d]: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_halt();
        vec_t       v[$];
        logic [4:0] e[$];
        logic [4:0] obs;
        logic [4:0] want;
        logic       h;
        // five cycles of halt_req, resume pulsed in the third
        for (int c = 1; c <= 5; c++) begin
            v.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, (c == 3) ? 1'b1 : 1'b0));
            e.push_back(O_HALT);
        end
        // halt released without resume: still halted; a branch is ignored
        v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0)); e.push_back(O_HALT);
        v.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1)); e.push_back(O_HALT);
        v.push_back(idle()); e.push_back(O_RUN);
        // load-use beats halt
        h = 1'b1;
        v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd6, 3'd6, 3'd0, 1'b0, h, 1'b0)); e.push_back(O_STALL);
        v.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, h, 1'b0)); e.push_back(O_HALT);
        // reset out of HALT and out of FLUSH leaves no residue
        v.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0)); e.push_back(O_RST);
        v.push_back(idle()); e.push_back(O_RUN);
        v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0)); e.push_back(O_BRANCH);
        v.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0)); e.push_back(O_RST);
        v.push_back(idle()); e.push_back(O_RUN);
        for (int i = 0; i < v.size(); i++) begin
            cyc(v[i], e[i]);
            obs  = {if_enable, branch_enable, ifid_hold, ifid_flush, idex_bubble};
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL halt[%0d]: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_perf();
        vec_t        v[$];
        logic [4:0]  e[$];
        logic [4:0]  obs;
        logic [4:0]  want;
        logic [15:0] exp_stall;
        logic [15:0] exp_flush;
        v.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0)); e.push_back(O_RST);
        for (int k = 0; k < 3; k++) begin
            v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0)); e.push_back(O_STALL);
            v.push_back(idle()); e.push_back(O_RUN);
        end
        for (int k = 0; k < 2; k++) begin
            v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0)); e.push_back(O_BRANCH);
            v.push_back(idle()); e.push_back(O_FLUSH);
        end
        v.push_back(idle()); e.push_back(O_RUN);
        for (int i = 0; i < v.size(); i++) begin
            cyc(v[i], e[i]);
            obs  = {if_enable, branch_enable, ifid_hold, ifid_flush, idex_bubble};
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL perf_seq[%0d]: got %b expected %b", i, obs, want);
            end
        end
`ifdef HAZ_PERF_CNT_EN
        exp_stall = 16'd3;
        exp_flush = 16'd4;
`else
        exp_stall = 16'd0;
        exp_flush = 16'd0;
`endif
        vectors++;
        if (stall_cnt !== exp_stall) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
        end
        vectors++;
        if (flush_cnt !== exp_flush) begin
            miscompares++;
            $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, exp_flush);
        end
`ifdef HAZ_PERF_CNT_EN
        // Continuous load-use drives stall_cnt into saturation.
        @(posedge clk);
        #1;
        ex_mem_read = 1'b1;
        ex_rd       = 3'd5;
        id_rs       = 3'd5;
        repeat (65540) @(posedge clk);
        #1;
        ex_mem_read = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stall_sat: got %h expected %h", stall_cnt, 16'hFFFF);
        end
`endif
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        ex_branch_tkn = 1'b0;
        ex_mem_read   = 1'b0;
        ex_rd         = 3'd0;
        id_rs         = 3'd0;
        id_rt         = 3'd0;
        id_uses_rt    = 1'b0;
        halt_req      = 1'b0;
        resume        = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_halt();
        test_perf();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
